// File: rtl/binary_to_bcd_seq_if.sv
// Start/busy/done handshake and data bus for the sequential binary-to-BCD converter.
interface binary_to_bcd_seq_if #(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                  start;
  logic [BIN_W-1:0]      binary;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (output start, binary, input busy, done, bcd, overflow);
  modport slave  (input start, binary, output busy, done, bcd, overflow);
endinterface

// File: rtl/binary_to_bcd_seq.sv
// Multi-cycle double-dabble converter: one input bit per clock, registered BCD
// result with a sticky overflow flag for values that exceed DIGITS digits.
module binary_to_bcd_seq #(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  binary_to_bcd_seq_if.slave   bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t             r_state, w_state_nxt;
  logic [BIN_W-1:0]   r_shift, w_shift_nxt;
  logic [BCD_W-1:0]   r_acc,   w_acc_nxt;
  logic [BCD_W-1:0]   r_bcd,   w_bcd_nxt;
  logic [BCD_W-1:0]   w_adj;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic               r_sticky, w_sticky_nxt;
  logic               r_ovf,    w_ovf_nxt;
  logic               r_done,   w_done_nxt;
  logic               r_busy,   w_busy_nxt;

  // Add-3 correction per digit; a digit is at most 9 here, so no nibble wraps.
  always_comb begin
    w_adj = r_acc;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (r_acc[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_acc    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_acc    <= w_acc_nxt;
      r_bcd    <= w_bcd_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sticky <= w_sticky_nxt;
      r_ovf    <= w_ovf_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_acc_nxt    = r_acc;
    w_bcd_nxt    = r_bcd;
    w_cnt_nxt    = r_cnt;
    w_sticky_nxt = r_sticky;
    w_ovf_nxt    = r_ovf;
    w_done_nxt   = 1'b0;
    w_busy_nxt   = r_busy;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (bus.start) begin
          w_state_nxt  = S_SHIFT;
          w_shift_nxt  = bus.binary;
          w_acc_nxt    = '0;
          w_sticky_nxt = 1'b0;
          w_cnt_nxt    = '0;
          w_busy_nxt   = 1'b1;
        end
      end
      S_SHIFT: begin
        // {acc, shift} moves left as one register; the acc MSB falls into overflow.
        w_shift_nxt  = r_shift << 1;
        w_acc_nxt    = {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
        w_sticky_nxt = r_sticky | w_adj[BCD_W-1];
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_IDLE;
          w_bcd_nxt   = w_acc_nxt;
          w_ovf_nxt   = w_sticky_nxt;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench for binary_to_bcd_seq across three parameter sets, checked
// against a decimal-digit reference model.
module tb_binary_to_bcd_seq;

  typedef struct {
    logic [23:0] bcd;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  binary_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if0 ();
  binary_to_bcd_seq_if #(.BIN_W(16), .DIGITS(4)) if1 ();
  binary_to_bcd_seq_if #(.BIN_W(10), .DIGITS(3)) if2 ();

  binary_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  binary_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  binary_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ref_conv(input longint unsigned v, input int d);
    exp_t r;
    r.bcd = '0;
    for (int i = 0; i < d; i++) begin
      r.bcd = r.bcd | (24'(v % 10) << (4 * i));
      v     = v / 10;
    end
    r.ovf = (v != 0);
    return r;
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare whenever a DUT presents done.
  logic prev_done0 = 1'b0, prev_done1 = 1'b0, prev_done2 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (if0.done) begin
      check("u0_busy_in_done", 64'(if0.busy), 0);
      check("u0_done_pulse", 64'(prev_done0), 0);
      if (q0.size() == 0) check("u0_unexpected_done", 1, 0);
      else begin
        e = q0.pop_front();
        check("u0_bcd", 64'(if0.bcd), 64'(e.bcd));
        check("u0_ovf", 64'(if0.overflow), 64'(e.ovf));
      end
    end
    prev_done0 = if0.done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (if1.done) begin
      check("u1_done_pulse", 64'(prev_done1), 0);
      if (q1.size() == 0) check("u1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        check("u1_bcd", 64'(if1.bcd), 64'(e.bcd));
        check("u1_ovf", 64'(if1.overflow), 64'(e.ovf));
      end
    end
    prev_done1 = if1.done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (if2.done) begin
      check("u2_done_pulse", 64'(prev_done2), 0);
      if (q2.size() == 0) check("u2_unexpected_done", 1, 0);
      else begin
        e = q2.pop_front();
        check("u2_bcd", 64'(if2.bcd), 64'(e.bcd));
        check("u2_ovf", 64'(if2.overflow), 64'(e.ovf));
      end
    end
    prev_done2 = if2.done;
  end

  // Waits for u0 done from the negedge after the accepting edge; counts cycles and busy cycles.
  task automatic wait_done0(output int cyc, output int bsy);
    cyc = 1;
    bsy = 0;
    while (!if0.done && cyc < 200) begin
      if (if0.busy) bsy++;
      @(negedge clk);
      cyc++;
    end
    if (!if0.done) check("u0_done_timeout", 0, 1);
  endtask

  task automatic go0(input logic [15:0] v, output int cyc, output int bsy);
    @(negedge clk);
    if0.start  = 1'b1;
    if0.binary = v;
    q0.push_back(ref_conv(64'(v), 5));
    @(negedge clk);
    if0.start = 1'b0;
    wait_done0(cyc, bsy);
  endtask

  task automatic go1(input logic [15:0] v);
    @(negedge clk);
    if1.start  = 1'b1;
    if1.binary = v;
    q1.push_back(ref_conv(64'(v), 4));
    @(negedge clk);
    if1.start = 1'b0;
    repeat (17) @(negedge clk);
  endtask

  task automatic go2(input logic [9:0] v);
    @(negedge clk);
    if2.start  = 1'b1;
    if2.binary = v;
    q2.push_back(ref_conv(64'(v), 3));
    @(negedge clk);
    if2.start = 1'b0;
    repeat (11) @(negedge clk);
  endtask

  initial begin
    int cyc, bsy;
    rst_n = 1'b0;
    if0.start = 1'b0; if0.binary = '0;
    if1.start = 1'b0; if1.binary = '0;
    if2.start = 1'b0; if2.binary = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(if0.busy), 0);
    check("rst_done", 64'(if0.done), 0);
    check("rst_bcd", 64'(if0.bcd), 0);
    check("rst_ovf", 64'(if0.overflow), 0);

    go0(16'hFFFF, cyc, bsy);
    check("ffff_latency", 64'(cyc), 17);
    check("ffff_busy_cycles", 64'(bsy), 16);
    go0(16'd0, cyc, bsy);
    go0(16'd2025, cyc, bsy);
    go0(16'd9999, cyc, bsy);

    // Start held high: binary changed mid-conversion must not affect the first result.
    @(negedge clk);
    if0.start  = 1'b1;
    if0.binary = 16'd100;
    q0.push_back(ref_conv(64'd100, 5));
    @(negedge clk);
    if0.binary = 16'd777;
    q0.push_back(ref_conv(64'd777, 5));
    wait_done0(cyc, bsy);
    check("held_first_latency", 64'(cyc), 17);
    @(negedge clk);
    if0.start = 1'b0;
    wait_done0(cyc, bsy);
    check("held_second_latency", 64'(cyc), 17);

    // Reset in the middle of a conversion aborts it with no done pulse.
    @(negedge clk);
    if0.start  = 1'b1;
    if0.binary = 16'd54321;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(if0.busy), 0);
    check("abort_bcd", 64'(if0.bcd), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_after_busy", 64'(if0.busy), 0);
    check("abort_after_bcd", 64'(if0.bcd), 0);
    check("abort_after_ovf", 64'(if0.overflow), 0);
    go0(16'd54321, cyc, bsy);

    go1(16'd12345);
    go1(16'd9999);
    go1(16'd10000);
    go1(16'hFFFF);

    go2(10'd0);
    go2(10'd999);
    go2(10'd1000);
    go2(10'd1023);
    for (int i = 0; i < 500; i++) go2(10'($urandom_range(0, 1023)));

    repeat (5) @(negedge clk);
    check("q0_drained", 64'(q0.size()), 0);
    check("q1_drained", 64'(q1.size()), 0);
    check("q2_drained", 64'(q2.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
